seg_scan_driver: RTL

- Time-multiplexed seven-segment scan stage. It sits directly downstream of the clock/timer block.
- Consumes six 8-bit segment patterns (hour/minute/second tens and units) and drives the board's shared segment bus plus one-hot digit enables.
- Adds anti-ghost blanking, per-slot input snapshot and optional set-mode blinking.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/scan_prescaler.sv | 61 ++++++
 rtl/seg_scan_driver.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg -- shared seven-segment definitions.
//
// Segment byte layout (active-high): bit 7 = a, bit 6 = b, ... bit 1 = g,
// bit 0 = dp. The timer's segment LUT uses the same constants, so both
// blocks agree on bit order without duplicating it.
package seg_pkg;

  localparam int SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Width of a counter covering 0..n-1, never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler -- slot timing for the seven-segment scan.
//
// Owns the slot counter (cnt, 0..SCAN_DIV-1) and the digit index
// (idx, 0..NUM_DIGITS-1). Both clear while enable is low; enable has
// priority over a slot end on the same edge.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   enable     display on; low clears cnt/idx
//   slot_start cnt == 0
//   visible    cnt >= BLANK_CYCLES
//   scan_done  last cycle of the last digit's slot, while enabled
//   idx        current digit index
module scan_prescaler
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int IDX_W        = cnt_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             slot_start,
  output logic             visible,
  output logic             scan_done,
  output logic [IDX_W-1:0] idx
);

  localparam int CNT_W = cnt_width(SCAN_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;

  assign slot_end   = (cnt == CNT_LAST);
  assign slot_start = (cnt == '0);
  assign visible    = (cnt >= CNT_BLANK);
  assign scan_done  = enable && slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver -- time-multiplexed seven-segment scan stage.
//
// Cycles through NUM_DIGITS patterns, SCAN_DIV clocks per digit. The first
// BLANK_CYCLES clocks of every slot drive all digits off to prevent ghosting.
// Each digit's pattern is captured once at the start of its slot, so seg_in
// may change at any time without tearing the displayed digit.
//
// Optional feature (macro BLINK_EN): every BLINK_SCANS full scans the blink
// phase toggles; while the phase is set, digits flagged in blink_mask show a
// blank pattern in their visible window (digit enable timing is unchanged).
// Without BLINK_EN, blink_mask is ignored.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   enable     display on; low blanks outputs and restarts at digit 0
//   seg_in     packed patterns, digit i in [8i+7:8i]
//   blink_mask per-digit blink select (BLINK_EN only)
//   tub_sel    one-hot digit enable, zero while blanked
//   seg_out    segment bus
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_SCANS  = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [NUM_DIGITS-1:0]       tub_sel,
  output logic [SEG_W-1:0]            seg_out
);

  localparam int IDX_W = cnt_width(NUM_DIGITS);

  logic             slot_start;
  logic             visible;
  logic             scan_done;
  logic [IDX_W-1:0] idx;
  logic [SEG_W-1:0] snap;
  logic             blink_kill;

  scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .slot_start(slot_start),
    .visible   (visible),
    .scan_done (scan_done),
    .idx       (idx)
  );

`ifdef BLINK_EN
  localparam int BLK_W = cnt_width(BLINK_SCANS);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SCANS - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Blink state survives enable=0 so the rhythm is not reset by power saving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (scan_done) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_kill = blink_phase && blink_mask[idx];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, scan_done};
  assign blink_kill   = 1'b0;
`endif

  // Snapshot at cnt==0 never collides with display: BLANK_CYCLES >= 1 keeps
  // cnt==0 inside the blank window, so the visible window always uses a
  // pattern captured earlier in the same slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap    <= SEG_BLANK;
      tub_sel <= '0;
      seg_out <= SEG_BLANK;
    end else if (!enable) begin
      tub_sel <= '0;
      seg_out <= SEG_BLANK;
    end else begin
      if (slot_start) begin
        snap <= seg_in[idx*SEG_W +: SEG_W];
      end
      if (!visible) begin
        tub_sel <= '0;
        seg_out <= SEG_BLANK;
      end else begin
        tub_sel <= NUM_DIGITS'(1) << idx;
        seg_out <= blink_kill ? SEG_BLANK : snap;
      end
    end
  end

endmodule
